// File: rtl/gate_truth_checker_if.sv
// Handshake and result bundle between a gate_truth_checker and the gate/controller around it.
interface gate_truth_checker_if #(
    parameter int N_IN  = 2,
    parameter int ERR_W = 4
);
    logic                  start;
    logic [(1<<N_IN)-1:0]  truth_tbl;
    logic                  y;
    logic [N_IN-1:0]       vec;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [ERR_W-1:0]      err_cnt;
    logic [N_IN-1:0]       fail_vec;
    logic                  fail_y;

    modport master (
        output start, truth_tbl, y,
        input  vec, busy, done, pass, err_cnt, fail_vec, fail_y
    );

    modport slave (
        input  start, truth_tbl, y,
        output vec, busy, done, pass, err_cnt, fail_vec, fail_y
    );
endinterface

// File: rtl/gate_truth_checker.sv
// Clocked truth-table sweep of a small combinational gate: drive vec, settle, sample y, count mismatches.
// Optional first-failure capture is enabled with `define GATE_CHK_FAILCAP_EN.
module gate_truth_checker #(
    parameter int N_IN       = 2,
    parameter int SETTLE_CYC = 2,
    parameter int ERR_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    gate_truth_checker_if.slave  bus
);
    localparam int NV    = 1 << N_IN;
    localparam int SET_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC);
    localparam logic [N_IN-1:0]  VEC_LAST    = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [NV-1:0]     tbl_q, tbl_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [ERR_W-1:0]  err_nxt;
    logic              mismatch;

`ifdef GATE_CHK_FAILCAP_EN
    logic [N_IN-1:0]   fail_vec_q, fail_vec_d;
    logic              fail_y_q, fail_y_d;
    logic              fail_seen_q, fail_seen_d;
`endif

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    // Case inequality so that an undriven or unknown gate output is flagged as wrong.
    assign mismatch = (bus.y !== tbl_q[vec_q]);

    always_comb begin
        state_d  = state_q;
        tbl_d    = tbl_q;
        vec_d    = vec_q;
        settle_d = settle_q;
        err_d    = err_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        err_nxt  = mismatch ? sat_inc(err_q) : err_q;
`ifdef GATE_CHK_FAILCAP_EN
        fail_vec_d  = fail_vec_q;
        fail_y_d    = fail_y_q;
        fail_seen_d = fail_seen_q;
`endif
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d  = S_HOLD;
                    tbl_d    = bus.truth_tbl;
                    vec_d    = '0;
                    settle_d = '0;
                    err_d    = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
`ifdef GATE_CHK_FAILCAP_EN
                    fail_vec_d  = '0;
                    fail_y_d    = 1'b0;
                    fail_seen_d = 1'b0;
`endif
                end
            end
            S_HOLD: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    err_d    = err_nxt;
`ifdef GATE_CHK_FAILCAP_EN
                    if (mismatch && !fail_seen_q) begin
                        fail_vec_d  = vec_q;
                        fail_y_d    = bus.y;
                        fail_seen_d = 1'b1;
                    end
`endif
                    if (vec_q == VEC_LAST) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_nxt == '0);
                    end else begin
                        vec_d = vec_q + N_IN'(1);
                    end
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            vec_q    <= '0;
            settle_q <= '0;
            err_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
`ifdef GATE_CHK_FAILCAP_EN
            fail_vec_q  <= '0;
            fail_y_q    <= 1'b0;
            fail_seen_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
`ifdef GATE_CHK_FAILCAP_EN
            fail_vec_q  <= fail_vec_d;
            fail_y_q    <= fail_y_d;
            fail_seen_q <= fail_seen_d;
`endif
        end
    end

    // The snapshot table is only read between a start and the next start, so it needs no reset.
    always_ff @(posedge clk) begin
        tbl_q <= tbl_d;
    end

    assign bus.vec     = vec_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.pass    = pass_q;
    assign bus.err_cnt = err_q;
`ifdef GATE_CHK_FAILCAP_EN
    assign bus.fail_vec = fail_vec_q;
    assign bus.fail_y   = fail_y_q;
`else
    assign bus.fail_vec = '0;
    assign bus.fail_y   = 1'b0;
`endif
endmodule

// File: tb/tb_gate_truth_checker.sv
// Scoreboard bench for gate_truth_checker: two instances (settle 2 / err width 4, settle 0 / err width 1).
module tb_gate_truth_checker;
    localparam int NV = 4;

    typedef struct {
        int err;
        int pass;
        int fvec;
        int fy;
        int done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    gate_truth_checker_if #(.N_IN(2), .ERR_W(4)) bus0 ();
    gate_truth_checker_if #(.N_IN(2), .ERR_W(1)) bus1 ();

    gate_truth_checker #(.N_IN(2), .SETTLE_CYC(2), .ERR_W(4)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave));
    gate_truth_checker #(.N_IN(2), .SETTLE_CYC(0), .ERR_W(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave));

    // Gate under check: 0 = NOR, 1 = stuck-0, 2 = stuck-1, 3 = arbitrary table.
    int         y_mode[2];
    logic [3:0] ftbl[2];

    function automatic logic gate_resp(input int mode, input logic [3:0] ft, input int k);
        case (mode)
            0:       return (k == 0);
            1:       return 1'b0;
            2:       return 1'b1;
            default: return ft[k];
        endcase
    endfunction

    assign bus0.y = gate_resp(y_mode[0], ftbl[0], int'(bus0.vec));
    assign bus1.y = gate_resp(y_mode[1], ftbl[1], int'(bus1.vec));

    function automatic int settle_of(input int u);
        return (u == 0) ? 2 : 0;
    endfunction

    function automatic exp_t model(input int u, input logic [3:0] tbl, input int mode,
                                   input logic [3:0] ft, input int t0);
        exp_t e;
        int   cnt = 0;
        int   first = -1;
        int   fy = 0;
        int   maxe = (u == 0) ? 15 : 1;
        for (int k = 0; k < NV; k++) begin
            logic r;
            r = gate_resp(mode, ft, k);
            if (r != tbl[k]) begin
                cnt++;
                if (first < 0) begin
                    first = k;
                    fy    = int'(r);
                end
            end
        end
        e.err  = (cnt > maxe) ? maxe : cnt;
        e.pass = (cnt == 0) ? 1 : 0;
`ifdef GATE_CHK_FAILCAP_EN
        e.fvec = (first < 0) ? 0 : first;
        e.fy   = fy;
`else
        e.fvec = 0;
        e.fy   = 0;
`endif
        e.done_cyc = t0 + NV * (settle_of(u) + 1);
        return e;
    endfunction

    exp_t sb[2][$];
    int   sw_t0[2];
    bit   sw_active[2];

    logic m_done[2], m_busy[2], m_pass[2], m_fy[2];
    int   m_vec[2], m_err[2], m_fv[2];
    always_comb begin
        m_done[0] = bus0.done;  m_busy[0] = bus0.busy;  m_pass[0] = bus0.pass;
        m_fy[0]   = bus0.fail_y;
        m_vec[0]  = int'(bus0.vec);  m_err[0] = int'(bus0.err_cnt);  m_fv[0] = int'(bus0.fail_vec);
        m_done[1] = bus1.done;  m_busy[1] = bus1.busy;  m_pass[1] = bus1.pass;
        m_fy[1]   = bus1.fail_y;
        m_vec[1]  = int'(bus1.vec);  m_err[1] = int'(bus1.err_cnt);  m_fv[1] = int'(bus1.fail_vec);
    end

    task automatic chk(input string nm, input int u, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s unit=%0d cyc=%0d actual=%0d expected=%0d", nm, u, cyc, act, exp);
        end
    endtask

    // Monitor: per-cycle vector schedule while sweeping, scoreboard pop on each rising done.
    bit done_prev[2];
    always @(negedge clk) begin : monitor
        int   j;
        int   per;
        exp_t e;
        for (int u = 0; u < 2; u++) begin
            per = settle_of(u) + 1;
            if (sw_active[u] && cyc >= sw_t0[u] && cyc < sw_t0[u] + NV * per) begin
                j = cyc - sw_t0[u];
                chk("vec_seq", u, m_vec[u], j / per);
                chk("busy_run", u, int'(m_busy[u]), 1);
                chk("done_run", u, int'(m_done[u]), 0);
            end
            if (m_done[u] && !done_prev[u]) begin
                if (sb[u].size() == 0) begin
                    chk("unexpected_done", u, 1, 0);
                end else begin
                    e = sb[u].pop_front();
                    chk("done_cycle", u, cyc, e.done_cyc);
                    chk("err_cnt", u, m_err[u], e.err);
                    chk("pass", u, int'(m_pass[u]), e.pass);
                    chk("fail_vec", u, m_fv[u], e.fvec);
                    chk("fail_y", u, int'(m_fy[u]), e.fy);
                    chk("vec_last", u, m_vec[u], NV - 1);
                    chk("busy_done", u, int'(m_busy[u]), 0);
                    sw_active[u] = 1'b0;
                end
            end
            done_prev[u] = m_done[u];
        end
    end

    task automatic issue(input int u, input logic [3:0] tbl, input int mode,
                         input logic [3:0] ft, input int hold_cyc);
        @(negedge clk);
        y_mode[u] = mode;
        ftbl[u]   = ft;
        if (u == 0) begin
            bus0.truth_tbl = tbl;
            bus0.start     = 1'b1;
        end else begin
            bus1.truth_tbl = tbl;
            bus1.start     = 1'b1;
        end
        sw_t0[u]     = cyc + 1;
        sw_active[u] = 1'b1;
        sb[u].push_back(model(u, tbl, mode, ft, cyc + 1));
        repeat (hold_cyc) @(negedge clk);
        if (u == 0) bus0.start = 1'b0;
        else        bus1.start = 1'b0;
    endtask

    task automatic wait_idle(input int u);
        for (int i = 0; i < 300 && sb[u].size() != 0; i++) @(negedge clk);
        if (sb[u].size() != 0) begin
            chk("sweep_timeout", u, sb[u].size(), 0);
            sb[u].delete();
            sw_active[u] = 1'b0;
        end
    endtask

    task automatic check_reset(input int u);
        chk("rst_vec", u, m_vec[u], 0);
        chk("rst_busy", u, int'(m_busy[u]), 0);
        chk("rst_done", u, int'(m_done[u]), 0);
        chk("rst_pass", u, int'(m_pass[u]), 0);
        chk("rst_err", u, m_err[u], 0);
        chk("rst_fail_vec", u, m_fv[u], 0);
        chk("rst_fail_y", u, int'(m_fy[u]), 0);
    endtask

    initial begin
        rst            = 1'b1;
        bus0.start     = 1'b0;
        bus1.start     = 1'b0;
        bus0.truth_tbl = '0;
        bus1.truth_tbl = '0;
        y_mode[0] = 0;  y_mode[1] = 0;
        ftbl[0]   = '0; ftbl[1]   = '0;
        repeat (3) @(negedge clk);
        check_reset(0);
        check_reset(1);
        rst = 1'b0;

        // Correct NOR, stuck-0, stuck-1 on the settle-2 instance.
        issue(0, 4'b0001, 0, 4'h0, 1);  wait_idle(0);
        issue(0, 4'b0001, 1, 4'h0, 1);  wait_idle(0);
        issue(0, 4'b0001, 2, 4'h0, 1);  wait_idle(0);

        // Mid-sweep start and table change must be ignored.
        issue(0, 4'b0001, 0, 4'h0, 1);
        while (cyc < sw_t0[0] + 4) @(negedge clk);
        bus0.start     = 1'b1;
        bus0.truth_tbl = 4'b1110;
        @(negedge clk);
        bus0.start = 1'b0;
        wait_idle(0);

        // Reset at cycle 7 of a sweep discards it entirely.
        issue(0, 4'b0001, 2, 4'h0, 1);
        while (cyc < sw_t0[0] + 6) @(negedge clk);
        rst          = 1'b1;
        sw_active[0] = 1'b0;
        sb[0].delete();
        @(negedge clk);
        rst = 1'b0;
        check_reset(0);
        repeat (3) @(negedge clk);
        chk("idle_after_rst", 0, int'(m_busy[0]), 0);

        // Settle-0 instance: correct NOR, restart with start held in DONE, saturating counter.
        issue(1, 4'b0001, 0, 4'h0, 1);  wait_idle(1);
        issue(1, 4'b0001, 0, 4'h0, 3);  wait_idle(1);
        issue(1, 4'b0001, 2, 4'h0, 1);  wait_idle(1);
        issue(1, 4'b0001, 1, 4'h0, 1);  wait_idle(1);

        for (int i = 0; i < 24; i++) begin
            int         u;
            logic [3:0] t;
            logic [3:0] f;
            int         m;
            u = i % 2;
            t = 4'($urandom);
            f = 4'($urandom);
            m = int'($urandom_range(0, 3));
            issue(u, t, m, f, 1);
            wait_idle(u);
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
